// File: rtl/rsa_os_array.sv
// rsa_os_array: output-stationary X x Y systolic MAC array computing C = A*B with
// runtime inner length, accumulate-across-jobs, signed saturation and bubble tolerance.
`timescale 1ns/1ps
`default_nettype none
module rsa_os_array #(
  parameter int X       = 4,
  parameter int Y       = 4,
  parameter int IN_LEN  = 8,
  parameter int ACC_LEN = 20,
  parameter int OUT_LEN = 16,
  parameter int N_MAX   = 16,
  parameter int CNT_W   = $clog2(N_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  cfg_val,
  input  logic [CNT_W-1:0]      cfg_n,
  input  logic                  cfg_acc,
  output logic                  cfg_rdy,
  input  logic                  Xin_val,
  input  logic [X*IN_LEN-1:0]   Xin_data,
  output logic                  Xin_rdy,
  input  logic                  Yin_val,
  input  logic [Y*IN_LEN-1:0]   Yin_data,
  output logic                  Yin_rdy,
  input  logic                  out_rdy,
  output logic                  out_val,
  output logic [OUT_LEN-1:0]    out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int FL_W = $clog2(X + Y);
  localparam int KW   = $clog2(X * Y + 1);
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(X + Y - 2);
  localparam logic [KW-1:0]   K_LAST  = KW'(X * Y - 1);
  localparam logic signed [ACC_LEN-1:0] SAT_HI = {{(ACC_LEN-OUT_LEN+1){1'b0}}, {(OUT_LEN-1){1'b1}}};
  localparam logic signed [ACC_LEN-1:0] SAT_LO = {{(ACC_LEN-OUT_LEN+1){1'b1}}, {(OUT_LEN-1){1'b0}}};

  function automatic logic [OUT_LEN-1:0] saturate(input logic signed [ACC_LEN-1:0] v);
    if (v > SAT_HI)      return SAT_HI[OUT_LEN-1:0];
    else if (v < SAT_LO) return SAT_LO[OUT_LEN-1:0];
    else                 return v[OUT_LEN-1:0];
  endfunction

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d, beat_q, beat_d;
  logic [FL_W-1:0]     flush_q, flush_d;
  logic [KW-1:0]       k_q, k_d, sel_k;
  logic                out_val_q, out_val_d, out_last_q, out_last_d;
  logic [OUT_LEN-1:0]  out_data_q, out_data_d;
  logic                fire, acc_clr;
  logic signed [ACC_LEN-1:0] acc_sel;

  logic [IN_LEN-1:0]   a_sk [X];
  logic                a_skv [X];
  logic [IN_LEN-1:0]   b_sk [Y];
  logic                b_skv [Y];
  logic [IN_LEN-1:0]   a_q [X][Y];
  logic [IN_LEN-1:0]   b_q [X][Y];
  logic                av_q [X][Y];
  logic                bv_q [X][Y];
  logic signed [ACC_LEN-1:0] acc_q [X][Y];

  // Each ready depends only on the opposite valid, so a beat never fires single-sided.
  assign fire     = (state_q == ST_LOAD) && Xin_val && Yin_val;
  assign Xin_rdy  = (state_q == ST_LOAD) && Yin_val;
  assign Yin_rdy  = (state_q == ST_LOAD) && Xin_val;
  assign cfg_rdy  = (state_q == ST_IDLE);
  assign busy     = (state_q != ST_IDLE);
  assign out_val  = out_val_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;

  for (genvar i = 0; i < X; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_sk[i]  = Xin_data[i*IN_LEN +: IN_LEN];
      assign a_skv[i] = fire;
    end else begin : g_delay
      logic [IN_LEN-1:0] d_q [i];
      logic              v_q [i];
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          for (int s = 0; s < i; s++) begin
            d_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          d_q[0] <= Xin_data[i*IN_LEN +: IN_LEN];
          v_q[0] <= fire;
          for (int s = 1; s < i; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end
      assign a_sk[i]  = d_q[i-1];
      assign a_skv[i] = v_q[i-1];
    end
  end

  for (genvar j = 0; j < Y; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_sk[j]  = Yin_data[j*IN_LEN +: IN_LEN];
      assign b_skv[j] = fire;
    end else begin : g_delay
      logic [IN_LEN-1:0] d_q [j];
      logic              v_q [j];
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          for (int s = 0; s < j; s++) begin
            d_q[s] <= '0;
            v_q[s] <= 1'b0;
          end
        end else begin
          d_q[0] <= Yin_data[j*IN_LEN +: IN_LEN];
          v_q[0] <= fire;
          for (int s = 1; s < j; s++) begin
            d_q[s] <= d_q[s-1];
            v_q[s] <= v_q[s-1];
          end
        end
      end
      assign b_sk[j]  = d_q[j-1];
      assign b_skv[j] = v_q[j-1];
    end
  end

  for (genvar i = 0; i < X; i++) begin : g_row
    for (genvar j = 0; j < Y; j++) begin : g_col
      logic [IN_LEN-1:0]          a_in, b_in;
      logic                       av_in, bv_in;
      logic signed [2*IN_LEN-1:0] prod;
      if (j == 0) begin : g_a_edge
        assign a_in  = a_sk[i];
        assign av_in = a_skv[i];
      end else begin : g_a_chain
        assign a_in  = a_q[i][j-1];
        assign av_in = av_q[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in  = b_sk[j];
        assign bv_in = b_skv[j];
      end else begin : g_b_chain
        assign b_in  = b_q[i-1][j];
        assign bv_in = bv_q[i-1][j];
      end
      assign prod = $signed(a_in) * $signed(b_in);
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          a_q[i][j]   <= '0;
          b_q[i][j]   <= '0;
          av_q[i][j]  <= 1'b0;
          bv_q[i][j]  <= 1'b0;
          acc_q[i][j] <= '0;
        end else begin
          a_q[i][j]  <= a_in;
          b_q[i][j]  <= b_in;
          av_q[i][j] <= av_in;
          bv_q[i][j] <= bv_in;
          if (acc_clr)
            acc_q[i][j] <= '0;
          else if (av_in && bv_in)
            acc_q[i][j] <= acc_q[i][j] + ACC_LEN'(prod);
        end
      end
    end
  end

  // While an element is presented, look ahead to the next one for the handshake edge.
  assign sel_k = out_val_q ? k_q + KW'(1) : k_q;

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < X; i++)
      for (int j = 0; j < Y; j++)
        if (sel_k == KW'(i * Y + j)) acc_sel = acc_q[i][j];
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    beat_d     = beat_q;
    flush_d    = flush_q;
    k_d        = k_q;
    out_val_d  = out_val_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    acc_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_val) begin
          n_d     = (cfg_n > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : cfg_n;
          acc_clr = !cfg_acc;
          beat_d  = '0;
          k_d     = '0;
          state_d = (cfg_n == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (fire) begin
          if (beat_q == n_q - CNT_W'(1)) begin
            beat_d  = '0;
            flush_d = '0;
            state_d = ST_FLUSH;
          end else begin
            beat_d = beat_q + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_q == FL_LAST) begin
          flush_d = '0;
          k_d     = '0;
          state_d = ST_DRAIN;
        end else begin
          flush_d = flush_q + FL_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!out_val_q) begin
          out_val_d  = 1'b1;
          out_data_d = saturate(acc_sel);
          out_last_d = (k_q == K_LAST);
        end else if (out_rdy) begin
          if (out_last_q) begin
            out_val_d  = 1'b0;
            out_last_d = 1'b0;
            out_data_d = '0;
            k_d        = '0;
            state_d    = ST_IDLE;
          end else begin
            k_d        = k_q + KW'(1);
            out_data_d = saturate(acc_sel);
            out_last_d = (k_q + KW'(1) == K_LAST);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      beat_q     <= '0;
      flush_q    <= '0;
      k_q        <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      beat_q     <= beat_d;
      flush_q    <= flush_d;
      k_q        <= k_d;
      out_val_q  <= out_val_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rsa_os_array.sv
// tb_rsa_os_array: randomized and directed jobs for rsa_os_array, checked against
// a matrix-product reference model with wraparound and saturation.
`timescale 1ns/1ps
`default_nettype none
module tb_rsa_os_array;
  localparam int X = 4, Y = 4, IN_LEN = 8, ACC_LEN = 20, OUT_LEN = 16, N_MAX = 16;
  localparam int CNT_W = $clog2(N_MAX + 1);
  localparam int K = X * Y;

  logic clk = 1'b0, sys_rst = 1'b0;
  logic cfg_val = 1'b0, cfg_acc = 1'b0, cfg_rdy;
  logic [CNT_W-1:0] cfg_n = '0;
  logic Xin_val = 1'b0, Xin_rdy, Yin_val = 1'b0, Yin_rdy;
  logic [X*IN_LEN-1:0] Xin_data = '0;
  logic [Y*IN_LEN-1:0] Yin_data = '0;
  logic out_rdy = 1'b0, out_val, out_last, busy;
  logic [OUT_LEN-1:0] out_data;

  rsa_os_array #(.X(X), .Y(Y), .IN_LEN(IN_LEN), .ACC_LEN(ACC_LEN), .OUT_LEN(OUT_LEN),
                 .N_MAX(N_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .sys_rst(sys_rst), .cfg_val(cfg_val), .cfg_n(cfg_n), .cfg_acc(cfg_acc),
    .cfg_rdy(cfg_rdy), .Xin_val(Xin_val), .Xin_data(Xin_data), .Xin_rdy(Xin_rdy),
    .Yin_val(Yin_val), .Yin_data(Yin_data), .Yin_rdy(Yin_rdy), .out_rdy(out_rdy),
    .out_val(out_val), .out_data(out_data), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int a_mem [N_MAX][X];
  int b_mem [N_MAX][Y];
  longint model_acc [K];
  int out_q [$];
  bit last_q [$];
  int fires, stall_bad, xy_bad, busy_cfg_bad, accept_cyc, last_fire_cyc, first_oval_cyc, done_cyc;

  function automatic longint wrap_acc(longint v);
    longint m;
    m = v & ((64'sd1 <<< ACC_LEN) - 1);
    if (m >= (64'sd1 <<< (ACC_LEN - 1))) m = m - (64'sd1 <<< ACC_LEN);
    return m;
  endfunction

  function automatic int exp_out(int k);
    longint hi, lo;
    hi = (64'sd1 <<< (OUT_LEN - 1)) - 1;
    lo = -(64'sd1 <<< (OUT_LEN - 1));
    if (model_acc[k] > hi) return int'(hi);
    if (model_acc[k] < lo) return int'(lo);
    return int'(model_acc[k]);
  endfunction

  function automatic void model_job(int ncfg, bit accm);
    int neff;
    neff = (ncfg > N_MAX) ? N_MAX : ncfg;
    if (!accm) for (int k = 0; k < K; k++) model_acc[k] = 0;
    for (int t = 0; t < neff; t++)
      for (int i = 0; i < X; i++)
        for (int j = 0; j < Y; j++)
          model_acc[i*Y+j] = wrap_acc(model_acc[i*Y+j] + longint'(a_mem[t][i]) * longint'(b_mem[t][j]));
  endfunction

  function automatic void fill_const(int av, int bv);
    for (int t = 0; t < N_MAX; t++) begin
      for (int i = 0; i < X; i++) a_mem[t][i] = av;
      for (int j = 0; j < Y; j++) b_mem[t][j] = bv;
    end
  endfunction

  function automatic void fill_identity();
    for (int t = 0; t < N_MAX; t++) begin
      for (int i = 0; i < X; i++) a_mem[t][i] = (i == t) ? 1 : 0;
      for (int j = 0; j < Y; j++) b_mem[t][j] = t * Y + j + 1;
    end
  endfunction

  function automatic void fill_random();
    for (int t = 0; t < N_MAX; t++) begin
      for (int i = 0; i < X; i++) a_mem[t][i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < Y; j++) b_mem[t][j] = int'($urandom_range(0, 255)) - 128;
    end
  endfunction

  // Drives one job (descriptor, beats, drain) and records what the DUT produced.
  task automatic do_job(input int ncfg, input bit accm, input bit bub, input bit bp, input bit junk);
    int beat, neff, guard;
    bit tog, prev_stall, done;
    logic [OUT_LEN-1:0] prev_data;
    logic prev_last;
    beat = 0; guard = 0; tog = 0; prev_stall = 0; done = 0; prev_data = '0; prev_last = 0;
    neff = (ncfg > N_MAX) ? N_MAX : ncfg;
    out_q.delete(); last_q.delete();
    fires = 0; stall_bad = 0; xy_bad = 0; busy_cfg_bad = 0; first_oval_cyc = -1; last_fire_cyc = -1;
    model_job(ncfg, accm);
    cfg_val = 1'b1; cfg_n = CNT_W'(ncfg); cfg_acc = accm;
    @(posedge clk); #1;
    accept_cyc = cyc;
    cfg_val = junk; cfg_n = '0; cfg_acc = 1'b0;
    while (!done && guard < 2000) begin
      tog = ~tog;
      Xin_val = (beat < neff);
      Yin_val = (beat < neff) && (!bub || tog);
      if (beat < neff) begin
        for (int i = 0; i < X; i++) Xin_data[i*IN_LEN +: IN_LEN] = IN_LEN'(a_mem[beat][i]);
        for (int j = 0; j < Y; j++) Yin_data[j*IN_LEN +: IN_LEN] = IN_LEN'(b_mem[beat][j]);
      end
      out_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if ((Xin_val && Xin_rdy) != (Yin_val && Yin_rdy)) xy_bad++;
      if (Xin_val && Xin_rdy && Yin_val && Yin_rdy) begin
        beat++; fires++; last_fire_cyc = cyc + 1;
      end
      if (junk && busy && cfg_rdy) busy_cfg_bad++;
      if (prev_stall && (!out_val || out_data !== prev_data || out_last !== prev_last)) stall_bad++;
      if (out_val && first_oval_cyc < 0) first_oval_cyc = cyc;
      prev_stall = out_val && !out_rdy; prev_data = out_data; prev_last = out_last;
      if (out_val && out_rdy) begin
        out_q.push_back(int'($signed(out_data)));
        last_q.push_back(out_last);
        if (out_last) begin
          done = 1; done_cyc = cyc + 1; cfg_val = 1'b0;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    Xin_val = 1'b0; Yin_val = 1'b0; out_rdy = 1'b0; cfg_val = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL job_timeout: n=%0d got %0d outputs, required completion within 2000 cycles", ncfg, out_q.size());
      sys_rst = 1'b0; #3; sys_rst = 1'b1;
      for (int k = 0; k < K; k++) model_acc[k] = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL reset_cfg_rdy: got %b want 1", cfg_rdy); end
    checks++; if (Xin_rdy !== 1'b0) begin errors++; $display("FAIL reset_xin_rdy: got %b want 0", Xin_rdy); end
    checks++; if (Yin_rdy !== 1'b0) begin errors++; $display("FAIL reset_yin_rdy: got %b want 0", Yin_rdy); end
    checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    repeat (2) @(posedge clk);
    @(negedge clk) sys_rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    fill_const(1, 2);
    do_job(1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (out_q.size() !== K) begin errors++; $display("FAIL basic_count: got %0d want %0d", out_q.size(), K); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
      checks++; if (last_q[k] !== (k == K - 1)) begin errors++; $display("FAIL basic_last[%0d]: got %b want %b", k, last_q[k], k == K - 1); end
    end
    checks++; if (first_oval_cyc - last_fire_cyc !== X + Y) begin
      errors++; $display("FAIL basic_latency: got %0d want %0d", first_oval_cyc - last_fire_cyc, X + Y); end
    checks++; if (busy_cfg_bad !== 0) begin errors++; $display("FAIL basic_cfg_while_busy: got %0d want 0", busy_cfg_bad); end
  endtask

  task automatic test_identity();
    fill_identity();
    do_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (out_q.size() !== K) begin errors++; $display("FAIL ident_count: got %0d want %0d", out_q.size(), K); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL ident_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
    checks++; if (done_cyc - accept_cyc !== 1 + 4 + X + Y - 1 + K) begin
      errors++; $display("FAIL ident_job_cycles: got %0d want %0d", done_cyc - accept_cyc, 1 + 4 + X + Y - 1 + K); end
  endtask

  task automatic test_saturation();
    for (int pass = 0; pass < 2; pass++) begin
      fill_const(pass == 0 ? 127 : -128, 127);
      do_job(16, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (out_q.size() !== K) begin errors++; $display("FAIL sat_count%0d: got %0d want %0d", pass, out_q.size(), K); end
      for (int k = 0; k < out_q.size(); k++) begin
        checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL sat%0d_data[%0d]: got %0d want %0d", pass, k, out_q[k], exp_out(k)); end
      end
    end
  endtask

  task automatic test_bubbles_backpressure();
    fill_identity();
    do_job(4, 1'b0, 1'b1, 1'b1, 1'b0);
    checks++; if (out_q.size() !== K) begin errors++; $display("FAIL bub_count: got %0d want %0d", out_q.size(), K); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL bub_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL bub_stall_stable: got %0d changes want 0", stall_bad); end
    checks++; if (xy_bad !== 0) begin errors++; $display("FAIL bub_one_sided: got %0d want 0", xy_bad); end
  endtask

  task automatic test_accumulate_empty();
    fill_const(1, 2);
    do_job(1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_job(1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (out_q.size() !== K) begin errors++; $display("FAIL acc_count: got %0d want %0d", out_q.size(), K); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL acc_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
    do_job(0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fires !== 0) begin errors++; $display("FAIL empty_fires: got %0d want 0", fires); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL empty_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
    fill_random();
    do_job(31, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (fires !== N_MAX) begin errors++; $display("FAIL clamp_fires: got %0d want %0d", fires, N_MAX); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL clamp_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
  endtask

  task automatic test_reset_mid_job();
    fill_identity();
    cfg_val = 1'b1; cfg_n = CNT_W'(4); cfg_acc = 1'b0;
    @(posedge clk); #1;
    cfg_val = 1'b0;
    for (int t = 0; t < 2; t++) begin
      Xin_val = 1'b1; Yin_val = 1'b1;
      for (int i = 0; i < X; i++) Xin_data[i*IN_LEN +: IN_LEN] = IN_LEN'(a_mem[t][i]);
      for (int j = 0; j < Y; j++) Yin_data[j*IN_LEN +: IN_LEN] = IN_LEN'(b_mem[t][j]);
      @(posedge clk); #1;
    end
    #3 sys_rst = 1'b0;
    #1;
    checks++; if (cfg_rdy !== 1'b1) begin errors++; $display("FAIL midrst_cfg_rdy: got %b want 1", cfg_rdy); end
    checks++; if (Xin_rdy !== 1'b0 || Yin_rdy !== 1'b0) begin
      errors++; $display("FAIL midrst_in_rdy: got %b%b want 00", Xin_rdy, Yin_rdy); end
    checks++; if (busy !== 1'b0 || out_val !== 1'b0 || out_last !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL midrst_outputs: got busy=%b val=%b last=%b data=%h want 0", busy, out_val, out_last, out_data); end
    Xin_val = 1'b0; Yin_val = 1'b0;
    #1 sys_rst = 1'b1;
    for (int k = 0; k < K; k++) model_acc[k] = 0;
    @(posedge clk); #1;
    do_job(4, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (out_q.size() !== K) begin errors++; $display("FAIL midrst_count: got %0d want %0d", out_q.size(), K); end
    for (int k = 0; k < out_q.size(); k++) begin
      checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL midrst_data[%0d]: got %0d want %0d", k, out_q[k], exp_out(k)); end
    end
  endtask

  task automatic test_random();
    int nn;
    bit am, bub, bp;
    for (int r = 0; r < 8; r++) begin
      fill_random();
      nn = int'($urandom_range(0, N_MAX + 3));
      am = 1'($urandom_range(0, 1));
      bub = 1'($urandom_range(0, 1));
      bp = 1'($urandom_range(0, 1));
      do_job(nn, am, bub, bp, 1'b0);
      checks++; if (fires !== ((nn > N_MAX) ? N_MAX : nn)) begin
        errors++; $display("FAIL rand%0d_fires: got %0d want %0d", r, fires, (nn > N_MAX) ? N_MAX : nn); end
      for (int k = 0; k < out_q.size(); k++) begin
        checks++; if (out_q[k] !== exp_out(k)) begin errors++; $display("FAIL rand%0d_data[%0d]: got %0d want %0d", r, k, out_q[k], exp_out(k)); end
      end
      checks++; if (stall_bad !== 0 || xy_bad !== 0) begin
        errors++; $display("FAIL rand%0d_protocol: got stall=%0d onesided=%0d want 0/0", r, stall_bad, xy_bad); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_saturation();
    test_bubbles_backpressure();
    test_accumulate_empty();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
